// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions: UART transmitter state encoding and default baud divisor.
package arch_defs_pkg;

  typedef enum logic [1:0] {UTX_IDLE, UTX_START, UTX_DATA, UTX_STOP} uart_tx_state_t;

  localparam int UART_CLKS_PER_BIT = 868;

endpackage

// File: rtl/out_port_uart_tx_fifo.sv
// Small synchronous FIFO with first-word-fall-through output; full/empty derive from count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the same edge frees a slot.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/out_port_uart_tx.sv
// OUT-register serial transmitter: captures each OUT load into a FIFO and sends it as an 8N1 frame.
module out_port_uart_tx
  import arch_defs_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          out_load,
  input  logic [DATA_WIDTH-1:0]         out_data,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_tx_state_t          state;
  logic [BW-1:0]           baud_cnt;
  logic [IW-1:0]           bit_idx;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [DATA_WIDTH-1:0]   fifo_dout;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    baud_wrap;

  assign baud_wrap = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  // Pop from IDLE, or at the end of STOP so the next frame follows with no idle gap.
  assign fifo_pop  = !fifo_empty && ((state == UTX_IDLE) || ((state == UTX_STOP) && baud_wrap));
  assign busy      = (state != UTX_IDLE) || (fifo_count != '0);

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_load),
    .pop   (fifo_pop),
    .din   (out_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (out_load && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UTX_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
    end else begin
      case (state)
        UTX_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (fifo_pop) begin
            shift_reg <= fifo_dout;
            tx        <= 1'b0;
            state     <= UTX_START;
          end
        end
        UTX_START: begin
          if (baud_wrap) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= UTX_DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        UTX_DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_idx == IW'(DATA_WIDTH - 1)) begin
              bit_idx <= '0;
              tx      <= 1'b1;
              state   <= UTX_STOP;
            end else begin
              bit_idx   <= bit_idx + IW'(1);
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        UTX_STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (fifo_pop) begin
              shift_reg <= fifo_dout;
              tx        <= 1'b0;
              state     <= UTX_START;
            end else begin
              state <= UTX_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state    <= UTX_IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

endmodule
